// File: rtl/present_pkg.sv
// Shared PRESENT-80 tables, layer functions and key-schedule steps; used by encrypt and decrypt cores.
// Pure combinational helpers, no state, no handshake.
package present_pkg;

  localparam int ROUNDS = 31;
  localparam int KEY_W  = 80;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX[x[4*i +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] sbox_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX_INV[x[4*i +: 4]];
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] p_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] key, input logic [4:0] ctr);
    logic [KEY_W-1:0] r;
    r          = {key[18:0], key[79:19]};
    r[79:76]   = SBOX[r[79:76]];
    r[19:15]   = r[19:15] ^ ctr;
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] key, input logic [4:0] ctr);
    logic [KEY_W-1:0] r;
    r          = key;
    r[19:15]   = r[19:15] ^ ctr;
    r[79:76]   = SBOX_INV[r[79:76]];
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_inv_round.sv
// One combinational PRESENT inverse round: steps the key back one round and undoes P/S layers.
// Zero latency, no handshake.
module present_inv_round
  import present_pkg::*;
(
  input  logic [63:0]      st,
  input  logic [KEY_W-1:0] key,
  input  logic [4:0]       ctr,
  output logic [63:0]      st_next,
  output logic [KEY_W-1:0] key_next
);

  assign key_next = key_inv(key, ctr);
  assign st_next  = sbox_inv_layer(p_inv_layer(st)) ^ key_next[79:16];

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: 31 key-expansion cycles then 31 inverse rounds; p valid 62 cycles after accept.
// in_ready only in IDLE; p/out_valid held in DONE until out_ready.
module present_decrypt
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      c,
  input  logic [KEY_W-1:0] k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      p
);

  state_t           state, state_nxt;
  logic [63:0]      st, st_nxt;
  logic [KEY_W-1:0] key_r, key_nxt;
  logic [4:0]       ctr, ctr_nxt;
  logic [63:0]      p_nxt;
  logic             out_valid_nxt;
  logic [KEY_W-1:0] fwd_key;
  logic [63:0]      rnd_st;
  logic [KEY_W-1:0] rnd_key;

  present_inv_round u_round (
    .st       (st),
    .key      (key_r),
    .ctr      (ctr),
    .st_next  (rnd_st),
    .key_next (rnd_key)
  );

  assign fwd_key  = key_fwd(key_r, ctr);
  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    st_nxt        = st;
    key_nxt       = key_r;
    ctr_nxt       = ctr;
    p_nxt         = p;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          key_nxt   = k;
          st_nxt    = c;
          ctr_nxt   = 5'd1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        key_nxt = fwd_key;
        // Last expansion step also applies the K32 whitening to the ciphertext.
        if (ctr == 5'(ROUNDS)) begin
          st_nxt    = st ^ fwd_key[79:16];
          state_nxt = DECRYPT;
        end else begin
          ctr_nxt = ctr + 5'd1;
        end
      end
      DECRYPT: begin
        st_nxt  = rnd_st;
        key_nxt = rnd_key;
        if (ctr == 5'd1) begin
          p_nxt         = rnd_st;
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          ctr_nxt = ctr - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= '0;
      key_r     <= '0;
      ctr       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      st        <= st_nxt;
      key_r     <= key_nxt;
      ctr       <= ctr_nxt;
      p         <= p_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule
